// File: rtl/ddr_frame_writer_pkg.sv
// ddr_frame_writer_pkg
// Shared definitions for the DDR frame writer: burst-sequencer state encoding,
// DDR word geometry and AXI write-response codes.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for FIFO data and frame space; applies frame restarts
// ST_ADDR   | write address presented, waiting for m_awready
// ST_DATA   | streaming FIFO words onto the write data channel
// ST_RESP   | waiting for the write response of the current burst
package ddr_frame_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_t;

    localparam int BYTES_PER_WORD = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Anything other than a plain OKAY is treated as a write error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_EXOKAY) || (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/ddr_wr_addr_gen.sv
// ddr_wr_addr_gen
// Tracks how many words of the current frame have been issued, computes the
// length and byte address of the next burst, and holds the ping-pong buffer
// select.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   clear_i         restart the frame (word counter to 0)
//   advance_i       address handshake: counter += burst length
//   toggle_i        frame completed: swap the active buffer
//   burst_len_o     beats in the next burst (1..BURST_LEN)
//   burst_addr_o    DDR byte address of the next burst
//   frame_full_o    every word of the frame has been issued
//   active_buf_o    buffer currently being written
module ddr_wr_addr_gen
    import ddr_frame_writer_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 28,
    parameter int                    BURST_LEN   = 16,
    parameter int                    FRAME_WORDS = 518400,
    parameter logic [ADDR_WIDTH-1:0] BUF0_BASE   = ADDR_WIDTH'('h0000000),
    parameter logic [ADDR_WIDTH-1:0] BUF1_BASE   = ADDR_WIDTH'('h0800000)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  advance_i,
    input  logic                  toggle_i,
    output logic [31:0]           burst_len_o,
    output logic [ADDR_WIDTH-1:0] burst_addr_o,
    output logic                  frame_full_o,
    output logic                  active_buf_o
);

    localparam int CNT_W      = $clog2(FRAME_WORDS + 1);
    localparam int BYTE_SHIFT = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] words_q;
    logic             active_buf_q;
    logic [31:0]      remaining;

    assign remaining    = 32'(FRAME_WORDS) - 32'(words_q);
    // The tail burst of a frame is shortened to whatever is left.
    assign burst_len_o  = (remaining < 32'(BURST_LEN)) ? remaining : 32'(BURST_LEN);
    assign burst_addr_o = (active_buf_q ? BUF1_BASE : BUF0_BASE)
                        + (ADDR_WIDTH'(words_q) << BYTE_SHIFT);
    assign frame_full_o = (words_q == CNT_W'(FRAME_WORDS));
    assign active_buf_o = active_buf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_q      <= '0;
            active_buf_q <= 1'b0;
        end else begin
            if (clear_i) begin
                words_q <= '0;
            end else if (advance_i) begin
                words_q <= words_q + CNT_W'(burst_len_o);
            end
            if (toggle_i) begin
                active_buf_q <= ~active_buf_q;
            end
        end
    end

endmodule

// File: rtl/ddr_frame_writer.sv
// ddr_frame_writer
// Drains a show-ahead prefetch FIFO of 128-bit video words into a ping-pong
// pair of DDR frame buffers using AXI write bursts.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   frame_start                   one-cycle pulse at start of each video frame
//   fifo_rd_en/_vld/_data         show-ahead FIFO pop interface
//   m_aw*, m_w*, m_b*             AXI write address / data / response channels
//   buf_idx                       last fully written buffer
//   frame_done                    one-cycle pulse when a frame has been written
//   wr_err                        sticky error on any non-OKAY response
module ddr_frame_writer
    import ddr_frame_writer_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 28,
    parameter int                    BURST_LEN   = 16,
    parameter int                    FRAME_WORDS = 518400,
    parameter logic [ADDR_WIDTH-1:0] BUF0_BASE   = ADDR_WIDTH'('h0000000),
    parameter logic [ADDR_WIDTH-1:0] BUF1_BASE   = ADDR_WIDTH'('h0800000)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    output logic                  fifo_rd_en,
    input  logic                  fifo_rd_vld,
    input  logic [127:0]          fifo_rd_data,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic [7:0]            m_awlen,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [127:0]          m_wdata,
    output logic [15:0]           m_wstrb,
    output logic                  m_wlast,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic                  buf_idx,
    output logic                  frame_done,
    output logic                  wr_err
);

    wr_state_t             state_q;
    logic [ADDR_WIDTH-1:0] m_awaddr_q;
    logic [7:0]            m_awlen_q;
    logic                  m_awvalid_q;
    logic                  m_bready_q;
    logic [7:0]            beat_q;
    logic                  pending_q;
    logic                  buf_idx_q;
    logic                  frame_done_q;
    logic                  wr_err_q;

    logic [31:0]           burst_len;
    logic [ADDR_WIDTH-1:0] burst_addr;
    logic                  frame_full;
    logic                  active_buf;
    logic                  in_data;
    logic                  w_hs;
    logic                  resp_done;
    logic                  gen_clear;
    logic                  gen_advance;
    logic                  gen_toggle;

    ddr_wr_addr_gen #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS),
        .BUF0_BASE   (BUF0_BASE),
        .BUF1_BASE   (BUF1_BASE)
    ) u_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (gen_clear),
        .advance_i    (gen_advance),
        .toggle_i     (gen_toggle),
        .burst_len_o  (burst_len),
        .burst_addr_o (burst_addr),
        .frame_full_o (frame_full),
        .active_buf_o (active_buf)
    );

    // The data channel is a straight pass-through of the FIFO head so a beat
    // and its pop always happen in the same cycle.
    assign in_data    = (state_q == ST_DATA);
    assign m_wvalid   = in_data && fifo_rd_vld;
    assign fifo_rd_en = in_data && m_wready;
    assign m_wdata    = fifo_rd_data;
    assign m_wstrb    = m_wvalid ? 16'hFFFF : 16'h0000;
    assign m_wlast    = in_data && (beat_q == m_awlen_q);
    assign w_hs       = m_wvalid && m_wready;

    assign m_awaddr   = m_awaddr_q;
    assign m_awlen    = m_awlen_q;
    assign m_awvalid  = m_awvalid_q;
    assign m_bready   = m_bready_q;
    assign buf_idx    = buf_idx_q;
    assign frame_done = frame_done_q;
    assign wr_err     = wr_err_q;

    assign resp_done   = (state_q == ST_RESP) && m_bvalid;
    assign gen_advance = (state_q == ST_ADDR) && m_awready;
    assign gen_toggle  = resp_done && frame_full;
    // A restart seen mid-burst is held until the burst's response returns;
    // a restart coinciding with the final response still lets the frame
    // complete (toggle) before the counter clears.
    assign gen_clear   = ((state_q == ST_IDLE) && frame_start)
                       || (resp_done && (pending_q || frame_start));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            m_awaddr_q   <= BUF0_BASE;
            m_awlen_q    <= 8'd0;
            m_awvalid_q  <= 1'b0;
            m_bready_q   <= 1'b0;
            beat_q       <= 8'd0;
            pending_q    <= 1'b0;
            buf_idx_q    <= 1'b1;
            frame_done_q <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (m_bvalid && resp_is_err(m_bresp)) begin
                wr_err_q <= 1'b1;
            end
            if (frame_start && (state_q != ST_IDLE)) begin
                pending_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    // A restart takes this cycle to clear the counter first.
                    if (!frame_start && fifo_rd_vld && !frame_full) begin
                        state_q     <= ST_ADDR;
                        m_awvalid_q <= 1'b1;
                        m_awaddr_q  <= burst_addr;
                        m_awlen_q   <= 8'(burst_len - 32'd1);
                    end
                end
                ST_ADDR: begin
                    if (m_awready) begin
                        m_awvalid_q <= 1'b0;
                        beat_q      <= 8'd0;
                        state_q     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_hs) begin
                        if (m_wlast) begin
                            m_bready_q <= 1'b1;
                            state_q    <= ST_RESP;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                        end
                    end
                end
                ST_RESP: begin
                    if (m_bvalid) begin
                        m_bready_q <= 1'b0;
                        pending_q  <= 1'b0;
                        state_q    <= ST_IDLE;
                        if (frame_full) begin
                            frame_done_q <= 1'b1;
                            buf_idx_q    <= active_buf;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_frame_writer.sv
// tb_ddr_frame_writer
// Scoreboard bench: every FIFO word pushed is also queued as an expected write
// beat, and every expected burst header is queued before it is due. A
// per-cycle monitor pops and compares on each AXI handshake.
module tb_ddr_frame_writer;

    localparam int          AW  = 28;
    localparam int          FW  = 40;
    localparam int          BL  = 16;
    localparam logic [27:0] B0  = 28'h0000000;
    localparam logic [27:0] B1  = 28'h0800000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic          fifo_rd_en;
    logic          fifo_rd_vld = 1'b0;
    logic [127:0]  fifo_rd_data = '0;
    logic [AW-1:0] m_awaddr;
    logic [7:0]    m_awlen;
    logic          m_awvalid;
    logic          m_awready = 1'b0;
    logic [127:0]  m_wdata;
    logic [15:0]   m_wstrb;
    logic          m_wlast;
    logic          m_wvalid;
    logic          m_wready = 1'b0;
    logic [1:0]    m_bresp = 2'b00;
    logic          m_bvalid = 1'b0;
    logic          m_bready;
    logic          buf_idx;
    logic          frame_done;
    logic          wr_err;

    always #5 clk = ~clk;

    ddr_frame_writer #(
        .ADDR_WIDTH  (AW),
        .BURST_LEN   (BL),
        .FRAME_WORDS (FW),
        .BUF0_BASE   (B0),
        .BUF1_BASE   (B1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_vld  (fifo_rd_vld),
        .fifo_rd_data (fifo_rd_data),
        .m_awaddr     (m_awaddr),
        .m_awlen      (m_awlen),
        .m_awvalid    (m_awvalid),
        .m_awready    (m_awready),
        .m_wdata      (m_wdata),
        .m_wstrb      (m_wstrb),
        .m_wlast      (m_wlast),
        .m_wvalid     (m_wvalid),
        .m_wready     (m_wready),
        .m_bresp      (m_bresp),
        .m_bvalid     (m_bvalid),
        .m_bready     (m_bready),
        .buf_idx      (buf_idx),
        .frame_done   (frame_done),
        .wr_err       (wr_err)
    );

    typedef struct packed {
        logic [27:0] addr;
        logic [7:0]  len;
    } aw_t;

    aw_t          exp_aw_q[$];
    logic [127:0] exp_w_q[$];
    logic [127:0] fifo_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int aw_cnt = 0;
    int b_cnt = 0;
    int fd_cnt = 0;
    int beat = 0;
    int cyc = 0;
    int aw_stall = 0;
    int word_seq = 0;

    logic        in_data = 1'b0;
    logic        b_pend = 1'b0;
    logic [7:0]  cur_len = 8'd0;
    logic        wr_toggle = 1'b0;
    logic        gap_en = 1'b0;
    logic        fs_pulse = 1'b0;
    logic        fs_arm = 1'b0;
    logic [1:0]  bresp_next = 2'b00;
    logic        prev_aw_wait = 1'b0;
    logic [27:0] prev_addr = '0;
    logic [7:0]  prev_len = '0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_words(input int n);
        logic [127:0] w;
        for (int i = 0; i < n; i++) begin
            word_seq++;
            w = {32'(word_seq), ~32'(word_seq), 32'(word_seq * 7), 32'hA5A5_0000 | 32'(i)};
            fifo_q.push_back(w);
            exp_w_q.push_back(w);
        end
    endtask

    task automatic exp_burst(input logic [27:0] addr, input logic [7:0] len);
        aw_t e;
        e.addr = addr;
        e.len  = len;
        exp_aw_q.push_back(e);
    endtask

    task automatic sample();
        logic aw_hs, w_hs, pop, b_hs;
        aw_t  e;
        aw_hs = m_awvalid && m_awready;
        w_hs  = m_wvalid && m_wready;
        pop   = fifo_rd_en && fifo_rd_vld;
        b_hs  = m_bvalid && m_bready;

        chk("wvalid_without_vld", 128'(m_wvalid && !fifo_rd_vld), 128'(0));
        chk("pop_vs_beat", 128'(pop), 128'(w_hs));
        chk("rd_en_outside_data", 128'(fifo_rd_en && !in_data), 128'(0));
        if (m_wvalid) chk("wstrb", 128'(m_wstrb), 128'(16'hFFFF));
        if (prev_aw_wait) begin
            chk("aw_hold_valid", 128'(m_awvalid), 128'(1));
            chk("aw_hold_addr", 128'(m_awaddr), 128'(prev_addr));
            chk("aw_hold_len", 128'(m_awlen), 128'(prev_len));
        end
        prev_aw_wait = m_awvalid && !m_awready;
        prev_addr    = m_awaddr;
        prev_len     = m_awlen;
        if (m_awvalid && !m_awready && aw_stall > 0) aw_stall--;
        if (frame_done) fd_cnt++;

        if (aw_hs) begin
            if (exp_aw_q.size() == 0) begin
                chk("aw_unexpected", 128'(1), 128'(0));
                cur_len = m_awlen;
            end else begin
                e = exp_aw_q.pop_front();
                chk("awaddr", 128'(m_awaddr), 128'(e.addr));
                chk("awlen", 128'(m_awlen), 128'(e.len));
                cur_len = e.len;
            end
            in_data = 1'b1;
            beat    = 0;
            aw_cnt++;
        end
        if (w_hs) begin
            chk("wlast", 128'(m_wlast), 128'(beat == int'(cur_len)));
            if (exp_w_q.size() == 0) chk("w_unexpected", 128'(1), 128'(0));
            else                     chk("wdata", m_wdata, exp_w_q.pop_front());
            if (beat == int'(cur_len)) begin
                in_data = 1'b0;
                b_pend  = 1'b1;
            end else begin
                beat++;
            end
        end
        if (pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (b_hs) begin
            b_pend = 1'b0;
            b_cnt++;
        end
    endtask

    task automatic step();
        logic fire;
        @(negedge clk);
        cyc++;
        fire        = fs_arm && in_data && (beat == 4);
        frame_start = fs_pulse || fire;
        if (fire) fs_arm = 1'b0;
        fs_pulse     = 1'b0;
        fifo_rd_vld  = (fifo_q.size() > 0) && !(gap_en && ($urandom_range(0, 2) == 0));
        fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        m_awready    = (aw_stall == 0);
        m_wready     = wr_toggle ? cyc[0] : 1'b1;
        m_bvalid     = b_pend;
        m_bresp      = b_pend ? bresp_next : 2'b00;
        #1;
        sample();
    endtask

    task automatic run_b(input int target, input int budget);
        for (int i = 0; i < budget && b_cnt < target; i++) step();
        chk("resp_count", 128'(b_cnt), 128'(target));
    endtask

    task automatic check_reset(input string p);
        chk({p, "_awvalid"}, 128'(m_awvalid), 128'(0));
        chk({p, "_wvalid"}, 128'(m_wvalid), 128'(0));
        chk({p, "_wlast"}, 128'(m_wlast), 128'(0));
        chk({p, "_bready"}, 128'(m_bready), 128'(0));
        chk({p, "_rd_en"}, 128'(fifo_rd_en), 128'(0));
        chk({p, "_frame_done"}, 128'(frame_done), 128'(0));
        chk({p, "_wr_err"}, 128'(wr_err), 128'(0));
        chk({p, "_buf_idx"}, 128'(buf_idx), 128'(1));
        chk({p, "_awaddr"}, 128'(m_awaddr), 128'(B0));
        chk({p, "_awlen"}, 128'(m_awlen), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_reset("rst");
        @(negedge clk);
        rst = 1'b0;

        // Frame 1 into buffer 0: two full bursts and a short tail.
        push_words(FW);
        exp_burst(B0, 8'd15);
        exp_burst(B0 + 28'h100, 8'd15);
        exp_burst(B0 + 28'h200, 8'd7);
        run_b(3, 400);
        step();
        step();
        chk("frame1_done_count", 128'(fd_cnt), 128'(1));
        chk("frame1_buf_idx", 128'(buf_idx), 128'(0));

        // Data waiting but frame is full: nothing may issue before frame_start.
        push_words(16);
        repeat (20) step();
        chk("idle_after_frame", 128'(aw_cnt), 128'(3));
        fs_pulse = 1'b1;
        exp_burst(B1, 8'd15);
        run_b(4, 200);

        // Frame 2 under backpressure, FIFO gaps and a stalled address channel.
        aw_stall  = 3;
        wr_toggle = 1'b1;
        gap_en    = 1'b1;
        push_words(16);
        exp_burst(B1 + 28'h100, 8'd15);
        run_b(5, 400);
        aw_stall = 2;
        push_words(8);
        exp_burst(B1 + 28'h200, 8'd7);
        run_b(6, 400);
        wr_toggle = 1'b0;
        gap_en    = 1'b0;
        step();
        step();
        chk("frame2_done_count", 128'(fd_cnt), 128'(2));
        chk("frame2_buf_idx", 128'(buf_idx), 128'(1));
        chk("fifo_drained", 128'(fifo_q.size()), 128'(0));
        chk("all_words_written", 128'(exp_w_q.size()), 128'(0));

        // Frame 3 restarted mid-burst: burst finishes, address returns to base.
        fs_pulse = 1'b1;
        fs_arm   = 1'b1;
        push_words(16);
        exp_burst(B0, 8'd15);
        run_b(7, 200);
        bresp_next = 2'b10;
        push_words(16);
        exp_burst(B0, 8'd15);
        run_b(8, 200);
        bresp_next = 2'b00;
        step();
        chk("abort_no_frame_done", 128'(fd_cnt), 128'(2));
        chk("abort_buf_idx", 128'(buf_idx), 128'(1));
        chk("wr_err_set", 128'(wr_err), 128'(1));
        repeat (5) step();
        chk("wr_err_sticky", 128'(wr_err), 128'(1));

        // Reset in the middle of a data phase.
        push_words(16);
        exp_burst(B0 + 28'h100, 8'd15);
        for (int i = 0; i < 100 && !(in_data && beat == 3); i++) step();
        chk("reached_beat3", 128'(in_data && beat == 3), 128'(1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset("midrst");
        fifo_q.delete();
        exp_w_q.delete();
        exp_aw_q.delete();
        in_data      = 1'b0;
        b_pend       = 1'b0;
        prev_aw_wait = 1'b0;
        fifo_rd_vld  = 1'b0;
        m_bvalid     = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // After reset the writer starts over at buffer 0, word 0.
        push_words(16);
        exp_burst(B0, 8'd15);
        run_b(9, 200);
        step();
        chk("post_rst_wr_err", 128'(wr_err), 128'(0));
        chk("post_rst_words", 128'(exp_w_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
